// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter
//   Drives the register-file write port. Each cycle it picks at most one writer:
//   either the in-order pipeline WB result or the head of a small FIFO of
//   long-latency unit completions (mul/div/load-miss). The choice is registered
//   onto rf_*. If the FIFO head keeps losing to WB, a one-cycle wb_stall gives it
//   the port. A per-register pending scoreboard is kept for decode's RAW/WAW
//   stall checks.
// Ports
//   clk, reset                      clock (rising edge), async active-high reset
//   wb_valid, wb_rd, wb_data        pipeline WB write request
//   lu_issue_valid, lu_issue_rd     long-latency issue; marks rd pending
//   lu_valid, lu_rd, lu_data        long-latency result; lu_ready = handshake
//   wb_stall                        registered; pipeline holds WB this cycle
//   rf_we, rf_waddr, rf_wdata       register file write port (registered)
//   pending                         scoreboard, bit r = xr result outstanding
module regfile_writeback_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        lu_issue_valid,
  input  logic [4:0]  lu_issue_rd,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        wb_stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pending
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    q_rd   [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [PW-1:0] rptr, wptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt, starve_next;

  logic        empty, full, wb_req, pop, wb_win, push;
  logic [31:0] clr_mask, set_mask, pending_next;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  // Only registered state feeds lu_ready; a same-cycle pop does not free a slot.
  assign lu_ready = !full;

  assign wb_req = wb_valid && (wb_rd != 5'd0);
  // A stall cycle forces the head out; otherwise the head only takes idle slots.
  assign pop    = !empty && (wb_stall || !wb_req);
  assign wb_win = !wb_stall && wb_req;
  // rd=0 results complete the handshake but are dropped here.
  assign push   = lu_valid && !full && (lu_rd != 5'd0);

  // Counts cycles the head is present but not popped.
  assign starve_next = (!empty && !pop) ? starve_cnt + 1'b1 : '0;

  // Set is applied after clear so a same-rd issue and retire leaves the bit set.
  assign clr_mask     = pop ? (32'd1 << q_rd[rptr]) : 32'd0;
  assign set_mask     = (lu_issue_valid && lu_issue_rd != 5'd0) ? (32'd1 << lu_issue_rd) : 32'd0;
  assign pending_next = ((pending & ~clr_mask) | set_mask) & ~32'd1;

  // Storage carries no reset; emptiness is tracked by the pointers/count only.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wptr]   <= lu_rd;
      q_data[wptr] <= lu_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr       <= '0;
      wptr       <= '0;
      count      <= '0;
      starve_cnt <= '0;
      wb_stall   <= 1'b0;
      rf_we      <= 1'b0;
      rf_waddr   <= 5'd0;
      rf_wdata   <= 32'd0;
      pending    <= 32'd0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      starve_cnt <= starve_next;
      wb_stall   <= (starve_next == SW'(STARVE_LIMIT));
      rf_we      <= pop || wb_win;
      if (pop) begin
        rf_waddr <= q_rd[rptr];
        rf_wdata <= q_data[rptr];
      end else if (wb_win) begin
        rf_waddr <= wb_rd;
        rf_wdata <= wb_data;
      end
      pending <= pending_next;
    end
  end
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
module tb_regfile_writeback_arbiter;
  localparam int DEPTH = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk, reset;
  logic        wb_valid, lu_issue_valid, lu_valid;
  logic [4:0]  wb_rd, lu_issue_rd, lu_rd;
  logic [31:0] wb_data, lu_data;
  logic        lu_ready, wb_stall, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, pending;

  regfile_writeback_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .lu_issue_valid(lu_issue_valid), .lu_issue_rd(lu_issue_rd),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data),
    .lu_ready(lu_ready), .wb_stall(wb_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: a queue of pending results plus the arbitration rules.
  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  int          m_starve;
  bit          m_stall;
  logic [31:0] m_pend;
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  task automatic model_reset();
    mq.delete();
    m_starve = 0; m_stall = 0; m_pend = 0;
    m_we = 0; m_waddr = 0; m_wdata = 0;
  endtask

  task automatic model_tick();
    bit wbreq, nonempty, ready, popped;
    ent_t e;
    wbreq    = wb_valid && (wb_rd != 0);
    nonempty = mq.size() > 0;
    ready    = mq.size() < DEPTH;
    popped   = 0;
    m_we     = 0;
    if (nonempty && (m_stall || !wbreq)) begin
      e = mq.pop_front();
      popped = 1; m_we = 1; m_waddr = e.rd; m_wdata = e.data;
      m_pend[e.rd] = 1'b0;
    end else if (!m_stall && wbreq) begin
      m_we = 1; m_waddr = wb_rd; m_wdata = wb_data;
    end
    if (lu_issue_valid && lu_issue_rd != 0) m_pend[lu_issue_rd] = 1'b1;
    if (lu_valid && ready && lu_rd != 0) begin
      e.rd = lu_rd; e.data = lu_data;
      mq.push_back(e);
    end
    m_starve = (nonempty && !popped) ? m_starve + 1 : 0;
    m_stall  = (m_starve == STARVE_LIMIT);
  endtask

  task automatic cmp_model();
    chk("m_rf_we",    {31'd0, rf_we},    {31'd0, m_we});
    chk("m_rf_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
    chk("m_rf_wdata", rf_wdata, m_wdata);
    chk("m_wb_stall", {31'd0, wb_stall}, {31'd0, m_stall});
    chk("m_pending",  pending, m_pend);
    chk("m_lu_ready", {31'd0, lu_ready}, {31'd0, (mq.size() < DEPTH)});
  endtask

  task automatic set_in(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                        input logic iv, input logic [4:0] ird,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    wb_valid = wv; wb_rd = wrd; wb_data = wd;
    lu_issue_valid = iv; lu_issue_rd = ird;
    lu_valid = lv; lu_rd = lrd; lu_data = ld;
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    cmp_model();
  endtask

  typedef struct {
    logic wv; logic [4:0] wrd; logic [31:0] wd;
    logic iv; logic [4:0] ird;
    logic lv; logic [4:0] lrd; logic [31:0] ld;
    logic e_we; logic [4:0] e_wa; logic [31:0] e_wd; logic [31:0] e_pend; logic e_rdy;
  } vec_t;
  vec_t vt[7];

  initial begin
    vt[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 32'hDEADBEEF, 32'h0,  1'b1};
    vt[1] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b0, 5'd0, 32'h0,    1'b0, 5'd5, 32'hDEADBEEF, 32'h80, 1'b1};
    vt[2] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd5, 32'hDEADBEEF, 32'h80, 1'b1};
    vt[3] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd5, 32'hDEADBEEF, 32'h80, 1'b1};
    vt[4] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'h1234,     32'h0,  1'b1};
    vt[5] = '{1'b1, 5'd0, 32'h77,       1'b0, 5'd0, 1'b1, 5'd0, 32'h55,   1'b0, 5'd7, 32'h1234,     32'h0,  1'b1};
    vt[6] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd7, 32'h1234,     32'h0,  1'b1};

    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    chk("rst_rf_we",    {31'd0, rf_we}, 32'd0);
    chk("rst_rf_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_wb_stall", {31'd0, wb_stall}, 32'd0);
    chk("rst_pending",  pending, 32'd0);
    chk("rst_lu_ready", {31'd0, lu_ready}, 32'd1);
    reset = 1'b0;

    // Directed table: WB write, issue/complete rd7, rd=0 cases.
    for (int i = 0; i < 7; i++) begin
      set_in(vt[i].wv, vt[i].wrd, vt[i].wd, vt[i].iv, vt[i].ird, vt[i].lv, vt[i].lrd, vt[i].ld);
      step();
      chk($sformatf("vec%0d_we", i),      {31'd0, rf_we},    {31'd0, vt[i].e_we});
      chk($sformatf("vec%0d_waddr", i),   {27'd0, rf_waddr}, {27'd0, vt[i].e_wa});
      chk($sformatf("vec%0d_wdata", i),   rf_wdata, vt[i].e_wd);
      chk($sformatf("vec%0d_pending", i), pending,  vt[i].e_pend);
      chk($sformatf("vec%0d_ready", i),   {31'd0, lu_ready}, {31'd0, vt[i].e_rdy});
    end

    // Starvation: one queued result under continuous WB.
    set_in(1, 5'd1, 32'h101, 0, 0, 1, 5'd9, 32'hA9);
    step();
    for (int k = 2; k <= 5; k++) begin
      set_in(1, 5'(k), 32'h100 + k, 0, 0, 0, 0, 0);
      step();
      chk($sformatf("starve_stall_c%0d", k - 1), {31'd0, wb_stall}, {31'd0, (k == 5)});
    end
    set_in(1, 5'd6, 32'h106, 0, 0, 0, 0, 0);
    step();
    chk("starve_pop_waddr", {27'd0, rf_waddr}, 32'd9);
    chk("starve_pop_wdata", rf_wdata, 32'hA9);
    chk("starve_stall_clr", {31'd0, wb_stall}, 32'd0);
    step();
    chk("starve_held_wb", {27'd0, rf_waddr}, 32'd6);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Fill FIFO under busy WB, blocked third result, order across wrap.
    set_in(1, 5'd10, 32'h10A, 0, 0, 1, 5'd20, 32'hB20); step();
    set_in(1, 5'd11, 32'h10B, 0, 0, 1, 5'd21, 32'hB21); step();
    chk("full_ready", {31'd0, lu_ready}, 32'd0);
    for (int k = 12; k <= 14; k++) begin
      set_in(1, 5'(k), 32'h100 + k, 0, 0, 1, 5'd22, 32'hB22);
      step();
    end
    chk("full_stall", {31'd0, wb_stall}, 32'd1);
    set_in(1, 5'd15, 32'h10F, 0, 0, 1, 5'd22, 32'hB22); step();
    chk("full_pop20", {27'd0, rf_waddr}, 32'd20);
    chk("full_noblock_bypass", {31'd0, lu_ready}, 32'd1);
    step();
    chk("full_wb15", {27'd0, rf_waddr}, 32'd15);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step(); chk("wrap_pop21", {27'd0, rf_waddr}, 32'd21);
    step(); chk("wrap_pop22", {27'd0, rf_waddr}, 32'd22);
    chk("wrap_data22", rf_wdata, 32'hB22);
    step(); chk("wrap_idle", {31'd0, rf_we}, 32'd0);

    // Async reset with entries queued and x7 pending.
    set_in(1, 5'd1, 32'h1, 1, 5'd7, 1, 5'd4, 32'hC4); step();
    set_in(1, 5'd2, 32'h2, 0, 0, 1, 5'd5, 32'hC5); step();
    chk("pre_rst_pending", pending, 32'h80);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_we",      {31'd0, rf_we}, 32'd0);
    chk("mid_rst_waddr",   {27'd0, rf_waddr}, 32'd0);
    chk("mid_rst_wdata",   rf_wdata, 32'd0);
    chk("mid_rst_pending", pending, 32'd0);
    chk("mid_rst_ready",   {31'd0, lu_ready}, 32'd1);
    chk("mid_rst_stall",   {31'd0, wb_stall}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_no_write", {31'd0, rf_we}, 32'd0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      set_in(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom,
             ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)),
             ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), $urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
